// File: rtl/snake_defs.sv
// Shared definitions for the snake frame loader.
//  - Default geometry of the snake body RAM and of the block coordinates.
//  - VGA vertical timing used to find the blanking window.
//  - Loader FSM state encoding.
//  - Bit positions of the one-hot direction vector {up,down,left,right}.
package snake_defs;

   localparam int PIXEL_DISPLAY_BIT = 9;
   localparam int SNAKE_LENGTH_BIT  = 4;
   localparam int SNAKE_LENGTH_MAX  = 16;
   localparam int COORD_BIT         = 7;
   localparam int V_VISIBLE         = 480;
   localparam int V_TOTAL           = 525;

   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SNAP = 2'd1,
      LOAD = 2'd2,
      DONE = 2'd3
   } load_state_t;

endpackage

// File: rtl/snake_read_pipe.sv
// Two-stage read alignment for the snake body RAM.
//  The RAM answers one cycle after an address is issued. Stage p0 carries the
//  issued index/valid/last flag alongside that latency; stage p1 registers the
//  returned coordinates together with their index so that body_count and the
//  coordinates always change on the same clock edge.
// Ports:
//  clock_25, reset          pixel clock, asynchronous active-low reset
//  issue_vld/idx/last       address issued this cycle, its index, last-segment flag
//  rd_x, rd_y               RAM data (valid one cycle after issue)
//  vld_p1, last_p1          a segment was presented this cycle / it was the last one
//  body_count, body_x/_y    presented segment index and coordinates (held when idle)
module snake_read_pipe #(
   parameter int IDX_W  = 4,
   parameter int DATA_W = 7
) (
   input  logic              clock_25,
   input  logic              reset,
   input  logic              issue_vld,
   input  logic              issue_last,
   input  logic [IDX_W-1:0]  issue_idx,
   input  logic [DATA_W-1:0] rd_x,
   input  logic [DATA_W-1:0] rd_y,
   output logic              vld_p1,
   output logic              last_p1,
   output logic [IDX_W-1:0]  body_count,
   output logic [DATA_W-1:0] body_x,
   output logic [DATA_W-1:0] body_y
);

   logic             vld_p0;
   logic             last_p0;
   logic [IDX_W-1:0] idx_p0;

   // Stage p0: index travels while the RAM performs its read
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         vld_p0  <= 1'b0;
         last_p0 <= 1'b0;
         idx_p0  <= '0;
      end else begin
         vld_p0  <= issue_vld;
         last_p0 <= issue_vld & issue_last;
         idx_p0  <= issue_idx;
      end
   end

   // Stage p1: index and returned data are registered together
   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         vld_p1     <= 1'b0;
         last_p1    <= 1'b0;
         body_count <= '0;
         body_x     <= '0;
         body_y     <= '0;
      end else begin
         vld_p1  <= vld_p0;
         last_p1 <= vld_p0 & last_p0;
         if (vld_p0) begin
            body_count <= idx_p0;
            body_x     <= rd_x;
            body_y     <= rd_y;
         end
      end
   end

endmodule

// File: rtl/snake_frame_loader.sv
// Copies the game-logic snake state into the renderer once per frame, during
// vertical blanking, so the visible area never shows a half-updated snake.
// Ports:
//  clock_25, reset                 pixel clock, asynchronous active-low reset
//  X, Y                            VGA screen counters (only Y matters here)
//  move_done                       pulse from game logic: state updated
//  len_in, head_*_in, fruit_*_in,
//  dir_in                          game state to snapshot ({up,down,left,right})
//  rd_addr / rd_x, rd_y            body RAM read port (one-cycle latency)
//  logic_lock                      game logic must hold still while high
//  body_count, snake_body_x/_y     streamed body segments for the renderer
//  snake_head_*, fruit_*,
//  snake_length, up/down/left/right  per-frame snapshots
//  frame_loaded                    one-cycle pulse when the copy is complete
module snake_frame_loader
   import snake_defs::*;
#(
   parameter int PIXEL_DISPLAY_BIT = snake_defs::PIXEL_DISPLAY_BIT,
   parameter int SNAKE_LENGTH_BIT  = snake_defs::SNAKE_LENGTH_BIT,
   parameter int SNAKE_LENGTH_MAX  = snake_defs::SNAKE_LENGTH_MAX,
   parameter int COORD_BIT         = snake_defs::COORD_BIT,
   parameter int V_VISIBLE         = snake_defs::V_VISIBLE,
   parameter int V_TOTAL           = snake_defs::V_TOTAL
) (
   input  logic                        clock_25,
   input  logic                        reset,
   input  logic [PIXEL_DISPLAY_BIT:0]  X,
   input  logic [PIXEL_DISPLAY_BIT:0]  Y,
   input  logic                        move_done,
   input  logic [SNAKE_LENGTH_BIT-1:0] len_in,
   input  logic [COORD_BIT-1:0]        head_x_in,
   input  logic [COORD_BIT-1:0]        head_y_in,
   input  logic [COORD_BIT-1:0]        fruit_x_in,
   input  logic [COORD_BIT-1:0]        fruit_y_in,
   input  logic [3:0]                  dir_in,
   output logic [SNAKE_LENGTH_BIT-1:0] rd_addr,
   input  logic [COORD_BIT-1:0]        rd_x,
   input  logic [COORD_BIT-1:0]        rd_y,
   output logic                        logic_lock,
   output logic [SNAKE_LENGTH_BIT-1:0] body_count,
   output logic [COORD_BIT-1:0]        snake_body_x,
   output logic [COORD_BIT-1:0]        snake_body_y,
   output logic [COORD_BIT-1:0]        snake_head_x,
   output logic [COORD_BIT-1:0]        snake_head_y,
   output logic [COORD_BIT-1:0]        fruit_x,
   output logic [COORD_BIT-1:0]        fruit_y,
   output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
   output logic                        up,
   output logic                        down,
   output logic                        left,
   output logic                        right,
   output logic                        frame_loaded
);

   // Lengths beyond the RAM depth are clamped; compared in int so that a
   // build where SNAKE_LENGTH_MAX does not fit the field never clamps.
   function automatic logic [SNAKE_LENGTH_BIT-1:0] sat_len(input logic [SNAKE_LENGTH_BIT-1:0] l);
      if (int'(l) > SNAKE_LENGTH_MAX)
         return SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX);
      return l;
   endfunction

   load_state_t                 state, state_next;
   logic                        pending;
   logic                        copied_this_blank;
   logic                        issue_done;
   logic                        issue_vld;
   logic                        issue_last;
   logic                        vld_p1;
   logic                        last_p1;
   logic                        vblank;
   logic [SNAKE_LENGTH_BIT-1:0] len_sat;
   logic [SNAKE_LENGTH_BIT-1:0] last_idx;
   logic                        unused_x;

   assign unused_x = ^X;

   // Last blanking line excluded so a copy always finishes before line 0.
   assign vblank   = (int'(Y) >= V_VISIBLE) && (int'(Y) < V_TOTAL - 1);
   assign len_sat  = sat_len(len_in);
   assign last_idx = snake_length - SNAKE_LENGTH_BIT'(1);

   assign issue_vld  = (state == LOAD) && !issue_done;
   assign issue_last = (rd_addr == last_idx);

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // copied_this_blank limits the loader to one copy per blanking interval;
   // a move_done seen during a copy is served in the next frame.
   always_comb begin
      state_next   = state;
      logic_lock   = (state != IDLE);
      frame_loaded = (state == DONE);
      case (state)
         IDLE: if (pending && vblank && !copied_this_blank) state_next = SNAP;
         SNAP: state_next = (len_sat == '0) ? DONE : LOAD;
         LOAD: if (vld_p1 && last_p1) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         pending           <= 1'b0;
         copied_this_blank <= 1'b0;
         issue_done        <= 1'b0;
         rd_addr           <= '0;
         snake_head_x      <= '0;
         snake_head_y      <= '0;
         fruit_x           <= '0;
         fruit_y           <= '0;
         snake_length      <= '0;
         up                <= 1'b0;
         down              <= 1'b0;
         left              <= 1'b0;
         right             <= 1'b0;
      end else begin
         // A pulse coinciding with the start of a copy is covered by that copy.
         if (state == IDLE && state_next == SNAP) pending <= 1'b0;
         else if (move_done)                      pending <= 1'b1;

         if (!vblank)            copied_this_blank <= 1'b0;
         else if (state == DONE) copied_this_blank <= 1'b1;

         case (state)
            SNAP: begin
               snake_head_x <= head_x_in;
               snake_head_y <= head_y_in;
               fruit_x      <= fruit_x_in;
               fruit_y      <= fruit_y_in;
               snake_length <= len_sat;
               up           <= dir_in[DIR_UP];
               down         <= dir_in[DIR_DOWN];
               left         <= dir_in[DIR_LEFT];
               right        <= dir_in[DIR_RIGHT];
               rd_addr      <= '0;
               issue_done   <= 1'b0;
            end
            LOAD: begin
               // Address stops at len-1 and holds; never wraps.
               if (issue_vld) begin
                  if (issue_last) issue_done <= 1'b1;
                  else            rd_addr    <= rd_addr + SNAKE_LENGTH_BIT'(1);
               end
            end
            default: ;
         endcase
      end
   end

   snake_read_pipe #(
      .IDX_W  (SNAKE_LENGTH_BIT),
      .DATA_W (COORD_BIT)
   ) u_read_pipe (
      .clock_25   (clock_25),
      .reset      (reset),
      .issue_vld  (issue_vld),
      .issue_last (issue_last),
      .issue_idx  (rd_addr),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .vld_p1     (vld_p1),
      .last_p1    (last_p1),
      .body_count (body_count),
      .body_x     (snake_body_x),
      .body_y     (snake_body_y)
   );

endmodule

// File: tb/tb_snake_frame_loader.sv
// Directed bench for snake_frame_loader (5-bit length build so that a
// 16-segment snake and length saturation can be exercised).
module tb_snake_frame_loader;

   localparam int LB = 5;
   localparam int CB = 7;

   logic          clock_25 = 1'b0;
   logic          reset = 1'b0;
   logic [9:0]    X = '0;
   logic [9:0]    Y = '0;
   logic          move_done = 1'b0;
   logic [LB-1:0] len_in = '0;
   logic [CB-1:0] head_x_in = '0, head_y_in = '0, fruit_x_in = '0, fruit_y_in = '0;
   logic [3:0]    dir_in = '0;
   logic [LB-1:0] rd_addr;
   logic [CB-1:0] rd_x = '0, rd_y = '0;
   logic          logic_lock;
   logic [LB-1:0] body_count;
   logic [CB-1:0] snake_body_x, snake_body_y, snake_head_x, snake_head_y, fruit_x, fruit_y;
   logic [LB-1:0] snake_length;
   logic          up, down, left, right;
   logic          frame_loaded;

   int errors = 0;
   int checks = 0;

   snake_frame_loader #(
      .SNAKE_LENGTH_BIT (LB),
      .SNAKE_LENGTH_MAX (16),
      .COORD_BIT        (CB)
   ) dut (
      .clock_25     (clock_25),
      .reset        (reset),
      .X            (X),
      .Y            (Y),
      .move_done    (move_done),
      .len_in       (len_in),
      .head_x_in    (head_x_in),
      .head_y_in    (head_y_in),
      .fruit_x_in   (fruit_x_in),
      .fruit_y_in   (fruit_y_in),
      .dir_in       (dir_in),
      .rd_addr      (rd_addr),
      .rd_x         (rd_x),
      .rd_y         (rd_y),
      .logic_lock   (logic_lock),
      .body_count   (body_count),
      .snake_body_x (snake_body_x),
      .snake_body_y (snake_body_y),
      .snake_head_x (snake_head_x),
      .snake_head_y (snake_head_y),
      .fruit_x      (fruit_x),
      .fruit_y      (fruit_y),
      .snake_length (snake_length),
      .up           (up),
      .down         (down),
      .left         (left),
      .right        (right),
      .frame_loaded (frame_loaded)
   );

   always #20 clock_25 = ~clock_25;

   function automatic logic [CB-1:0] mx(input int k);
      return CB'(k * 5 + 3);
   endfunction

   function automatic logic [CB-1:0] my(input int k);
      return CB'(100 - k);
   endfunction

   // Body RAM model: one-cycle read latency.
   always @(posedge clock_25) begin
      rd_x <= mx(int'(rd_addr));
      rd_y <= my(int'(rd_addr));
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_25);
      #1;
   endtask

   // Counts lock / frame_loaded cycles over n cycles with no copy expected.
   task automatic quiet(input string tag, input int n);
      int cnt;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (logic_lock !== 1'b0 || frame_loaded !== 1'b0) cnt++;
      end
      chk(tag, cnt, 0);
   endtask

   // Waits (bounded) for SNAP, then follows the copy cycle by cycle.
   // i=0 is the SNAP cycle; segment k is expected at i=3+k.
   task automatic run_copy(input string tag, input int max_wait, input int exp_len, input int pulse_at);
      int waited, lock_cycles, fl_at;
      waited = 0;
      while (logic_lock !== 1'b1 && waited < max_wait) begin
         tick();
         waited++;
      end
      chk({tag, "_start"}, logic_lock, 1);
      if (logic_lock !== 1'b1) return;
      lock_cycles = 0;
      fl_at = -1;
      for (int i = 0; i < exp_len + 8; i++) begin
         move_done = (i == pulse_at);
         if (logic_lock === 1'b1) lock_cycles++;
         if (frame_loaded === 1'b1 && fl_at < 0) fl_at = i;
         if (i >= 3 && i < 3 + exp_len) begin
            chk($sformatf("%s_idx%0d", tag, i - 3), body_count, i - 3);
            chk($sformatf("%s_x%0d", tag, i - 3), snake_body_x, mx(i - 3));
            chk($sformatf("%s_y%0d", tag, i - 3), snake_body_y, my(i - 3));
         end
         tick();
      end
      move_done = 1'b0;
      chk({tag, "_lock_cycles"}, lock_cycles, (exp_len == 0) ? 2 : exp_len + 4);
      chk({tag, "_loaded_at"}, fl_at, (exp_len == 0) ? 1 : exp_len + 3);
   endtask

   task automatic pulse_move();
      move_done = 1'b1;
      tick();
      move_done = 1'b0;
   endtask

   task automatic new_frame();
      Y = 10'd0;
      tick();
      Y = 10'd480;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_lock", logic_lock, 0);
      chk("rst_loaded", frame_loaded, 0);
      chk("rst_count", body_count, 0);
      chk("rst_len", snake_length, 0);
      chk("rst_addr", rd_addr, 0);
      reset = 1'b1;
      tick();

      // 1: move_done in the visible area waits for blanking
      Y = 10'd100;
      len_in = 5'd4;
      head_x_in = 7'd10; head_y_in = 7'd20; fruit_x_in = 7'd30; fruit_y_in = 7'd40;
      dir_in = 4'b0010;
      pulse_move();
      quiet("t1_no_early", 6);
      Y = 10'd480;
      run_copy("t1", 1, 4, -1);
      chk("t1_head_x", snake_head_x, 10);
      chk("t1_head_y", snake_head_y, 20);
      chk("t1_fruit_x", fruit_x, 30);
      chk("t1_fruit_y", fruit_y, 40);
      chk("t1_dir", {up, down, left, right}, 4'b0010);
      chk("t1_len", snake_length, 4);
      chk("t1_hold_idx", body_count, 3);
      chk("t1_hold_x", snake_body_x, mx(3));

      // 2: move_done inside blanking starts at once; on the last line it is deferred
      Y = 10'd0;
      tick();
      Y = 10'd500;
      len_in = 5'd2;
      head_x_in = 7'd11;
      dir_in = 4'b1000;
      pulse_move();
      run_copy("t2a", 1, 2, -1);
      chk("t2a_dir", {up, down, left, right}, 4'b1000);
      chk("t2a_head_x", snake_head_x, 11);
      Y = 10'd524;
      pulse_move();
      quiet("t2_line524_deferred", 6);
      new_frame();
      run_copy("t2b", 1, 2, -1);

      // 3: several pulses merge; a pulse during LOAD is served next frame
      Y = 10'd100;
      len_in = 5'd3;
      pulse_move();
      tick();
      pulse_move();
      tick();
      Y = 10'd480;
      run_copy("t3a", 1, 3, 2);
      quiet("t3_one_per_frame", 6);
      new_frame();
      run_copy("t3b", 1, 3, -1);
      new_frame();
      quiet("t3_no_extra", 6);

      // 4: zero length: SNAP then DONE, body outputs untouched
      len_in = 5'd0;
      new_frame();
      pulse_move();
      run_copy("t4", 1, 0, -1);
      chk("t4_idx_kept", body_count, 2);
      chk("t4_x_kept", snake_body_x, mx(2));
      chk("t4_y_kept", snake_body_y, my(2));
      chk("t4_len", snake_length, 0);

      // 5: full-depth snake and saturation of an oversize length
      len_in = 5'd16;
      new_frame();
      pulse_move();
      run_copy("t5", 1, 16, -1);
      chk("t5_len", snake_length, 16);
      chk("t5_hold_idx", body_count, 15);
      chk("t5_addr_hold", rd_addr, 15);
      len_in = 5'd20;
      new_frame();
      pulse_move();
      run_copy("t5s", 1, 16, -1);
      chk("t5s_len_sat", snake_length, 16);
      chk("t5s_hold_idx", body_count, 15);

      // 6: asynchronous reset in the middle of a copy
      len_in = 5'd4;
      head_x_in = 7'd55;
      new_frame();
      pulse_move();
      tick();
      chk("t6_snap", logic_lock, 1);
      repeat (5) tick();
      chk("t6_pre_idx", body_count, 2);
      reset = 1'b0;
      #2;
      chk("t6_lock0", logic_lock, 0);
      chk("t6_loaded0", frame_loaded, 0);
      chk("t6_idx0", body_count, 0);
      chk("t6_bx0", snake_body_x, 0);
      chk("t6_by0", snake_body_y, 0);
      chk("t6_hx0", snake_head_x, 0);
      chk("t6_len0", snake_length, 0);
      chk("t6_dir0", {up, down, left, right}, 0);
      chk("t6_addr0", rd_addr, 0);
      tick();
      reset = 1'b1;
      quiet("t6_idle_after_reset", 10);
      pulse_move();
      run_copy("t6r", 1, 4, -1);
      chk("t6r_head_x", snake_head_x, 55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
